// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with stall, strobes and line count
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  output logic          o_de,
  output logic          o_hs,
  output logic          o_vs,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_sof,
  output logic          o_sol,
  output logic [CW-1:0] o_line
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h;
  logic [CW-1:0] v;

  logic de_c;
  logic hs_win;
  logic vs_win;

  assign de_c   = (h < H_ACT) && (v < V_ACT);
  assign hs_win = (h >= HS_START) && (h < HS_END);
  assign vs_win = (v >= VS_START) && (v < VS_END);

  // Outputs are a registered decode of the pre-edge (h,v), so all stay aligned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h      <= '0;
      v      <= '0;
      o_de   <= 1'b0;
      o_hs   <= ~HS_POL;
      o_vs   <= ~VS_POL;
      o_x    <= '0;
      o_y    <= '0;
      o_sof  <= 1'b0;
      o_sol  <= 1'b0;
      o_line <= '0;
    end else if (i_en) begin
      o_de   <= de_c;
      o_hs   <= hs_win ? HS_POL : ~HS_POL;
      o_vs   <= vs_win ? VS_POL : ~VS_POL;
      o_x    <= de_c ? h : '0;
      o_y    <= de_c ? v : '0;
      o_sof  <= (h == '0) && (v == '0);
      o_sol  <= (h == '0) && (v < V_ACT);
      o_line <= v;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end else begin
      // Strobes are dropped during a stall so each fires once per pixel.
      o_sof <= 1'b0;
      o_sol <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized self-checking bench for video_timing_gen against a pixel-index model
module tb_video_timing_gen;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        sol;
    logic [11:0] line;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic d_de, d_hs, d_vs, d_sof, d_sol;
  logic [11:0] d_x, d_y, d_line;
  logic s_de, s_hs, s_vs, s_sof, s_sol;
  logic [11:0] s_x, s_y, s_line;

  video_timing_gen dut_d (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_de(d_de), .o_hs(d_hs), .o_vs(d_vs), .o_x(d_x), .o_y(d_y),
    .o_sof(d_sof), .o_sol(d_sol), .o_line(d_line)
  );

  video_timing_gen #(
    .CW(12), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_de(s_de), .o_hs(s_hs), .o_vs(s_vs), .o_x(s_x), .o_y(s_y),
    .o_sof(s_sof), .o_sol(s_sol), .o_line(s_line)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: pixel n since reset maps to h = n % H_TOTAL, v = (n / H_TOTAL) % V_TOTAL.
  function automatic out_t model_out(input int n, input int ha, input int hf, input int hsw, input int hb,
                                     input int va, input int vf, input int vsw, input int vb,
                                     input bit hp, input bit vp);
    out_t o;
    int ht, vt, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    h = n % ht;
    v = (n / ht) % vt;
    o.de   = (h < ha) && (v < va);
    o.hs   = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    o.vs   = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    o.x    = o.de ? 12'(h) : 12'd0;
    o.y    = o.de ? 12'(v) : 12'd0;
    o.sof  = (h == 0) && (v == 0);
    o.sol  = (h == 0) && (v < va);
    o.line = 12'(v);
    return o;
  endfunction

  function automatic out_t reset_out(input bit hp, input bit vp);
    out_t o;
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    return o;
  endfunction

  int   nd = 0, ns = 0;
  out_t ed, es;
  bit   last_en = 1'b0;
  bit   chk_on = 1'b0;

  always @(posedge clk) begin
    last_en = en && !rst;
    if (rst) begin
      nd = 0;
      ns = 0;
      ed = reset_out(1'b0, 1'b0);
      es = reset_out(1'b1, 1'b1);
    end else if (en) begin
      ed = model_out(nd, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
      es = model_out(ns, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
      nd++;
      ns++;
    end else begin
      ed.sof = 1'b0; ed.sol = 1'b0;
      es.sof = 1'b0; es.sol = 1'b0;
    end
  end

  // Compare process plus literal run-length monitors during the constant-enable phase.
  int  cyc = 0;
  bit  lit_on = 1'b0;
  int  de_rise = -1, hs_fall = -1, sof_last = -1, shs_rise = -1, svs_rise = -1;
  logic p_de = 0, p_hs = 1, p_ssof = 0, p_shs = 0, p_svs = 0;

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      check("d_de", d_de, ed.de);     check("d_hs", d_hs, ed.hs);
      check("d_vs", d_vs, ed.vs);     check("d_x", d_x, ed.x);
      check("d_y", d_y, ed.y);        check("d_sof", d_sof, ed.sof);
      check("d_sol", d_sol, ed.sol);  check("d_line", d_line, ed.line);
      check("s_de", s_de, es.de);     check("s_hs", s_hs, es.hs);
      check("s_vs", s_vs, es.vs);     check("s_x", s_x, es.x);
      check("s_y", s_y, es.y);        check("s_sof", s_sof, es.sof);
      check("s_sol", s_sol, es.sol);  check("s_line", s_line, es.line);
      if (!last_en) begin
        check("stall_strobe_d", {d_sof, d_sol}, 0);
        check("stall_strobe_s", {s_sof, s_sol}, 0);
      end
    end
    if (lit_on) begin
      if (d_de && !p_de) de_rise = cyc;
      if (!d_de && p_de && de_rise >= 0) check("de_run_640", cyc - de_rise, 640);
      if (!d_hs && p_hs) begin
        hs_fall = cyc;
        if (de_rise >= 0) check("hs_start_656", cyc - de_rise, 656);
      end
      if (d_hs && !p_hs && hs_fall >= 0) check("hs_low_96", cyc - hs_fall, 96);
      if (s_sof && !p_ssof) begin
        if (sof_last >= 0) check("s_frame_98", cyc - sof_last, 98);
        sof_last = cyc;
      end
      if (s_hs && !p_shs) shs_rise = cyc;
      if (!s_hs && p_shs && shs_rise >= 0) check("s_hs_high_2", cyc - shs_rise, 2);
      if (s_vs && !p_svs) svs_rise = cyc;
      if (!s_vs && p_svs && svs_rise >= 0) check("s_vs_high_14", cyc - svs_rise, 14);
    end
    p_de = d_de; p_hs = d_hs; p_ssof = s_sof; p_shs = s_hs; p_svs = s_vs;
  end

  task automatic check_first_pixel(input string tag);
    check({tag, "_d_sof"}, d_sof, 1);  check({tag, "_d_sol"}, d_sol, 1);
    check({tag, "_d_de"}, d_de, 1);    check({tag, "_d_x"}, d_x, 0);
    check({tag, "_s_sof"}, s_sof, 1);  check({tag, "_s_de"}, s_de, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_d_de"}, d_de, 0);    check({tag, "_d_hs"}, d_hs, 1);
    check({tag, "_d_vs"}, d_vs, 1);    check({tag, "_d_line"}, d_line, 0);
    check({tag, "_d_sof"}, d_sof, 0);  check({tag, "_s_hs"}, s_hs, 0);
    check({tag, "_s_vs"}, s_vs, 0);    check({tag, "_s_line"}, s_line, 0);
  endtask

  initial begin
    bit hit;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check_reset_vals("rst");

    rst = 1'b0;
    en  = 1'b1;
    lit_on = 1'b1;
    @(negedge clk);
    check_first_pixel("first");
    repeat (2000) @(negedge clk);
    lit_on = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 99) < 60);
      @(negedge clk);
    end

    en  = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (ns % 98 == 3 * 14 + 5) hit = 1'b1;
      else @(negedge clk);
    end
    check("reach_line3_px5", hit, 1);
    en  = ($urandom_range(0, 1) == 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    check_first_pixel("restart");
    for (int i = 0; i < 1000; i++) begin
      en = ($urandom_range(0, 99) < 80);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
